// File: rtl/readout_sched_pkg.sv
// Shared types and sizing for the readout scheduler.
package readout_sched_pkg;

    localparam int NSRC   = 12;
    localparam int NENT_W = 5;
    localparam int SEL_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] idx_sel(input int i);
        return i[SEL_W-1:0];
    endfunction

endpackage

// File: rtl/readout_scheduler_lsb_pick.sv
// Lowest-set-bit picker over the pending mask; purely combinational.
module sched_lsb_pick
    import readout_sched_pkg::*;
(
    input  logic [NSRC-1:0]  mask,
    output logic [SEL_W-1:0] sel,
    output logic             any_set
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        sel     = '0;
        any_set = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (mask[i]) begin
                sel     = idx_sel(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/readout_scheduler.sv
// Per-event readout sequencer: reads every non-empty block, lowest index first.
// Optional READOUT_TRUNC_EN caps the number of reads per event at TRUNC.
module readout_scheduler
    import readout_sched_pkg::*;
#(
    parameter int RD_LAT = 2
`ifdef READOUT_TRUNC_EN
   ,parameter int TRUNC  = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NSRC*NENT_W-1:0] nent,
    input  logic                   out_ready,
    output logic                   rd_en,
    output logic [SEL_W-1:0]       rd_sel,
    output logic [NENT_W-1:0]      rd_addr,
    output logic                   out_valid,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   start_err,
    output logic                   truncated
);

    state_t                  state;
    logic [NSRC*NENT_W-1:0]  nent_q;
    logic [NSRC-1:0]         pending;
    logic [NSRC-1:0]         new_mask;
    logic [NSRC-1:0]         rest_mask;
    logic [NSRC-1:0]         pick_mask;
    logic [SEL_W-1:0]        pick_sel;
    logic                    pick_any;
    logic [NENT_W-1:0]       cur_nent;
    logic                    last_entry;
    logic                    trunc_hit;
    logic                    finish_now;
    logic                    done_q;
    logic [RD_LAT-1:0]       vpipe;
    logic [SEL_W-1:0]        spipe [RD_LAT];

    always_comb begin
        new_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            new_mask[i] = |nent[i*NENT_W +: NENT_W];
        end
    end

    assign rd_en      = (state == READ) && out_ready;
    assign busy       = (state == READ);
    assign cur_nent   = nent_q[int'(rd_sel)*NENT_W +: NENT_W];
    assign last_entry = (rd_addr == cur_nent - 1'b1);
    assign rest_mask  = pending & ~(NSRC'(1) << rd_sel);
    // One picker serves both the first pick on start and the next-block pick.
    assign pick_mask  = start ? new_mask : rest_mask;

    sched_lsb_pick u_pick (
        .mask    (pick_mask),
        .sel     (pick_sel),
        .any_set (pick_any)
    );

`ifdef READOUT_TRUNC_EN
    localparam int CNT_W = $clog2(TRUNC + 1);
    logic [CNT_W-1:0] rd_cnt;
    assign trunc_hit = rd_en && (rd_cnt == CNT_W'(TRUNC - 1));
    assign truncated = trunc_hit && !start;
`else
    assign trunc_hit = 1'b0;
    assign truncated = 1'b0;
`endif

    // A new start overrides the natural end of an event, so it owns the done pulse.
    assign finish_now = rd_en && !start && (trunc_hit || (last_entry && !pick_any));
    assign done       = done_q || finish_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nent_q    <= '0;
            pending   <= '0;
            rd_sel    <= '0;
            rd_addr   <= '0;
            done_q    <= 1'b0;
            start_err <= 1'b0;
`ifdef READOUT_TRUNC_EN
            rd_cnt    <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            start_err <= 1'b0;
            if (start) begin
                nent_q    <= nent;
                pending   <= new_mask;
                rd_sel    <= pick_sel;
                rd_addr   <= '0;
                start_err <= (state == READ);
                done_q    <= (state == READ) || !pick_any;
                state     <= pick_any ? READ : IDLE;
`ifdef READOUT_TRUNC_EN
                rd_cnt    <= '0;
`endif
            end else if (rd_en) begin
`ifdef READOUT_TRUNC_EN
                rd_cnt <= rd_cnt + 1'b1;
`endif
                if (trunc_hit) begin
                    pending <= '0;
                    rd_addr <= '0;
                    state   <= IDLE;
                end else if (last_entry) begin
                    pending <= rest_mask;
                    rd_addr <= '0;
                    if (pick_any) begin
                        rd_sel <= pick_sel;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    // Delay pipe keeps shifting during stalls so it stays aligned with memory data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                spipe[i] <= '0;
            end
        end else begin
            vpipe[0] <= rd_en;
            spipe[0] <= rd_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                spipe[i] <= spipe[i-1];
            end
        end
    end

    assign out_valid = vpipe[RD_LAT-1];
    assign out_sel   = spipe[RD_LAT-1];

endmodule

// File: tb/tb_readout_scheduler.sv
// Scoreboard bench for readout_scheduler; define READOUT_TRUNC_EN to exercise truncation.
module tb_readout_scheduler;
    import readout_sched_pkg::*;

    localparam int RD_LAT = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [NSRC*NENT_W-1:0] nent;
    logic                   out_ready;
    logic                   rd_en;
    logic [SEL_W-1:0]       rd_sel;
    logic [NENT_W-1:0]      rd_addr;
    logic                   out_valid;
    logic [SEL_W-1:0]       out_sel;
    logic                   busy;
    logic                   done;
    logic                   start_err;
    logic                   truncated;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int exp_sel[$];
    int exp_addr[$];
    int exp_osel[$];
    int rd_cyc[$];

    readout_scheduler #(
        .RD_LAT (RD_LAT)
`ifdef READOUT_TRUNC_EN
       ,.TRUNC  (5)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .nent      (nent),
        .out_ready (out_ready),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .busy      (busy),
        .done      (done),
        .start_err (start_err),
        .truncated (truncated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_blk(input int sel, input int count);
        for (int a = 0; a < count; a++) begin
            exp_sel.push_back(sel);
            exp_addr.push_back(a);
            exp_osel.push_back(sel);
        end
    endtask

    task automatic apply_stimulus(input logic [NSRC*NENT_W-1:0] v);
        @(posedge clk);
        #1;
        nent  = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles (and reads) until done, bounded so a stuck DUT still finishes.
    task automatic wait_done(input int max_cyc, output int cyc, output int rds, output int busy_seen);
        cyc = 0;
        rds = 0;
        busy_seen = 0;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (rd_en) rds++;
            if (busy) busy_seen = 1;
            if (done) break;
        end
    endtask

    task automatic drain(input string name);
        repeat (RD_LAT + 2) @(posedge clk);
        check_output({name, "_rd_queue_left"}, exp_sel.size(), 0);
        check_output({name, "_out_queue_left"}, exp_osel.size(), 0);
    endtask

    // Monitor: every read and every out_valid is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (exp_sel.size() == 0) begin
                    check_output("unexpected_rd_en", 1, 0);
                end else begin
                    check_output("rd_sel", int'(rd_sel), exp_sel.pop_front());
                    check_output("rd_addr", int'(rd_addr), exp_addr.pop_front());
                end
                rd_cyc.push_back(cycle);
            end
            if (out_valid) begin
                if (exp_osel.size() == 0 || rd_cyc.size() == 0) begin
                    check_output("unexpected_out_valid", 1, 0);
                end else begin
                    check_output("out_sel", int'(out_sel), exp_osel.pop_front());
                    check_output("out_latency", cycle - rd_cyc.pop_front(), RD_LAT);
                end
            end
        end
    end

    initial begin
        logic [NSRC*NENT_W-1:0] v;
        int cyc, rds, bsy, ovs;

        rst_n     = 1'b0;
        start     = 1'b0;
        nent      = '0;
        out_ready = 1'b1;
        #12;
        check_output("reset_rd_en", int'(rd_en), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_start_err", int'(start_err), 0);
        check_output("reset_truncated", int'(truncated), 0);
        #10;
        rst_n = 1'b1;

        // Empty event: done one cycle after start, never busy.
        apply_stimulus('0);
        wait_done(10, cyc, rds, bsy);
        check_output("empty_done_cycle", cyc, 1);
        check_output("empty_reads", rds, 0);
        check_output("empty_busy", bsy, 0);
        drain("empty");

        // Single block with a mid-event stall of three cycles.
        v = '0;
        v[2*NENT_W +: NENT_W] = 5'd4;
        push_blk(2, 4);
        apply_stimulus(v);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("stall_rd_en", int'(rd_en), 0);
            check_output("stall_rd_addr", int'(rd_addr), 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(10, cyc, rds, bsy);
        check_output("stall_done_cycle", cyc, 2);
        check_output("stall_reads", rds, 2);
        drain("stall");

`ifndef READOUT_TRUNC_EN
        // Three sparse blocks back to back with no gap cycles.
        v = '0;
        v[0*NENT_W +: NENT_W]  = 5'd3;
        v[5*NENT_W +: NENT_W]  = 5'd2;
        v[11*NENT_W +: NENT_W] = 5'd2;
        push_blk(0, 3);
        push_blk(5, 2);
        push_blk(11, 2);
        apply_stimulus(v);
        wait_done(20, cyc, rds, bsy);
        check_output("sparse_done_cycle", cyc, 7);
        check_output("sparse_reads", rds, 7);
        check_output("sparse_busy_at_done", int'(busy), 1);
        check_output("sparse_truncated", int'(truncated), 0);
        @(negedge clk);
        check_output("sparse_busy_after", int'(busy), 0);
        drain("sparse");

        // Largest block in the last slot: address reaches 30 without wrapping.
        v = '0;
        v[11*NENT_W +: NENT_W] = 5'd31;
        push_blk(11, 31);
        apply_stimulus(v);
        wait_done(50, cyc, rds, bsy);
        check_output("full_done_cycle", cyc, 31);
        check_output("full_reads", rds, 31);
        drain("full");

        // Start while busy aborts after 4 reads and relaunches with new counts.
        v = '0;
        v[1*NENT_W +: NENT_W] = 5'd6;
        v[3*NENT_W +: NENT_W] = 5'd4;
        push_blk(1, 4);
        push_blk(7, 2);
        push_blk(9, 1);
        apply_stimulus(v);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        v = '0;
        v[7*NENT_W +: NENT_W] = 5'd2;
        v[9*NENT_W +: NENT_W] = 5'd1;
        nent  = v;
        start = 1'b1;
        @(negedge clk);
        check_output("abort_no_early_err", int'(start_err), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_output("abort_start_err", int'(start_err), 1);
        check_output("abort_done", int'(done), 1);
        check_output("abort_busy", int'(busy), 1);
        wait_done(10, cyc, rds, bsy);
        check_output("abort_new_done_cycle", cyc, 2);
        check_output("abort_new_reads", rds, 2);
        drain("abort");

        // Asynchronous reset mid-event discards everything in flight.
        v = '0;
        v[0*NENT_W +: NENT_W] = 5'd8;
        push_blk(0, 8);
        apply_stimulus(v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_rd_en", int'(rd_en), 0);
        check_output("midrst_busy", int'(busy), 0);
        check_output("midrst_out_valid", int'(out_valid), 0);
        check_output("midrst_rd_addr", int'(rd_addr), 0);
        check_output("midrst_rd_sel", int'(rd_sel), 0);
        exp_sel.delete();
        exp_addr.delete();
        exp_osel.delete();
        rd_cyc.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        ovs = 0;
        bsy = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) ovs++;
            if (busy) bsy = 1;
        end
        check_output("postrst_out_valid", ovs, 0);
        check_output("postrst_busy", bsy, 0);
`else
        // Nine entries with a five-read cap.
        v = '0;
        v[0*NENT_W +: NENT_W] = 5'd4;
        v[4*NENT_W +: NENT_W] = 5'd5;
        push_blk(0, 4);
        push_blk(4, 1);
        apply_stimulus(v);
        wait_done(20, cyc, rds, bsy);
        check_output("trunc_done_cycle", cyc, 5);
        check_output("trunc_reads", rds, 5);
        check_output("trunc_flag", int'(truncated), 1);
        @(negedge clk);
        check_output("trunc_busy_after", int'(busy), 0);
        check_output("trunc_flag_after", int'(truncated), 0);
        drain("trunc");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
